// File: rtl/wb_initiator_pkg.sv
// Shared state encoding and bus widths for the fabric-side Wishbone initiator.
package wb_initiator_pkg;

    localparam int WB_ADR_W = 17;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int TO_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/wb_ack_timeout.sv
// Saturating ACK-wait counter: counts bus cycles without ACK and flags when the limit is reached.
module wb_ack_timeout
    import wb_initiator_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [TO_CNT_W-1:0] limit_i,
    output logic                expired_o
);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == limit_i);

    // NOTE: assign the default first so every path through always_comb drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_initiator_seq.sv
// Single-outstanding Wishbone initiator: valid/ready command in, one bus beat with ACK timeout,
// valid/ready response out. Every output comes straight from a flop.
module wb_initiator_seq
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                WB_CLK,
    input  logic                WB_RST_N,
    input  logic                Cmd_Valid,
    output logic                Cmd_Ready,
    input  logic [WB_ADR_W-1:0] Cmd_Addr,
    input  logic [WB_DAT_W-1:0] Cmd_Wdata,
    input  logic [WB_SEL_W-1:0] Cmd_Byte_Stb,
    input  logic                Cmd_We,
    output logic [WB_ADR_W-1:0] WBm_ADR,
    output logic                WBm_CYC,
    output logic                WBm_STB,
    output logic                WBm_WE,
    output logic                WBm_RD,
    output logic [WB_SEL_W-1:0] WBm_BYTE_STB,
    output logic [WB_DAT_W-1:0] WBm_WR_DAT,
    input  logic [WB_DAT_W-1:0] WBm_RD_DAT,
    input  logic                WBm_ACK,
    output logic                Rsp_Valid,
    input  logic                Rsp_Ready,
    output logic [WB_DAT_W-1:0] Rsp_Rdata,
    output logic                Rsp_Err,
    output logic                Rsp_We
);

    state_e              state_q;
    logic                cmd_ready_q;
    logic                cyc_q;
    logic                we_q;
    logic                rd_q;
    logic [WB_ADR_W-1:0] adr_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic [WB_DAT_W-1:0] wdat_q;
    logic                rsp_valid_q;
    logic [WB_DAT_W-1:0] rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_we_q;
    logic                expired;

    // Counter is held at zero while idle, so it starts from zero on the first BUS cycle.
    wb_ack_timeout u_ack_timeout (
        .clk       (WB_CLK),
        .rst_n     (WB_RST_N),
        .clear_i   (state_q == IDLE),
        .enable_i  ((state_q == BUS) && !WBm_ACK),
        .limit_i   (TO_CNT_W'(TIMEOUT_CYCLES)),
        .expired_o (expired)
    );

    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_N) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Cmd_Valid) begin
                        state_q     <= BUS;
                        cmd_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        we_q        <= Cmd_We;
                        rd_q        <= ~Cmd_We;
                        adr_q       <= Cmd_Addr;
                        sel_q       <= Cmd_Byte_Stb;
                        wdat_q      <= Cmd_Wdata;
                    end
                end
                BUS: begin
                    // ACK wins over a timeout reached in the same cycle.
                    if (WBm_ACK || expired) begin
                        state_q     <= RESP;
                        cyc_q       <= 1'b0;
                        rd_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= we_q;
                        rsp_err_q   <= ~WBm_ACK;
                        rsp_rdata_q <= (WBm_ACK && !we_q) ? WBm_RD_DAT : '0;
                    end
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Cmd_Ready    = cmd_ready_q;
    assign WBm_ADR      = adr_q;
    assign WBm_CYC      = cyc_q;
    assign WBm_STB      = cyc_q;
    assign WBm_WE       = we_q;
    assign WBm_RD       = rd_q;
    assign WBm_BYTE_STB = sel_q;
    assign WBm_WR_DAT   = wdat_q;
    assign Rsp_Valid    = rsp_valid_q;
    assign Rsp_Rdata    = rsp_rdata_q;
    assign Rsp_Err      = rsp_err_q;
    assign Rsp_We       = rsp_we_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Directed bench for wb_initiator_seq: a transaction-level model checked every cycle,
// plus literal expectations for latency, cycle counts and captured data.
module tb_wb_initiator_seq;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [16:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_stb = '0;
    logic        cmd_we = 1'b0;
    logic [16:0] adr;
    logic        cyc, stb, we, rd;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rd_dat = '0;
    logic        ack = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_we;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    wb_initiator_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .WB_CLK       (clk),
        .WB_RST_N     (rst_n),
        .Cmd_Valid    (cmd_valid),
        .Cmd_Ready    (cmd_ready),
        .Cmd_Addr     (cmd_addr),
        .Cmd_Wdata    (cmd_wdata),
        .Cmd_Byte_Stb (cmd_stb),
        .Cmd_We       (cmd_we),
        .WBm_ADR      (adr),
        .WBm_CYC      (cyc),
        .WBm_STB      (stb),
        .WBm_WE       (we),
        .WBm_RD       (rd),
        .WBm_BYTE_STB (sel),
        .WBm_WR_DAT   (wdat),
        .WBm_RD_DAT   (rd_dat),
        .WBm_ACK      (ack),
        .Rsp_Valid    (rsp_valid),
        .Rsp_Ready    (rsp_ready),
        .Rsp_Rdata    (rsp_rdata),
        .Rsp_Err      (rsp_err),
        .Rsp_We       (rsp_we)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: a command is taken whenever nothing is in flight, the bus is held until
    // ACK or until TO+1 bus cycles have elapsed, and the response waits for Rsp_Ready.
    bit          m_known = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_pend = 1'b0;
    int          m_elapsed = 0;
    logic        e_ready, e_cyc, e_we, e_rv, e_err, e_rwe;
    logic [16:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_wdat, e_rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_pend  = 1'b0;
            e_ready = 1'b1;  e_cyc = 1'b0;  e_we = 1'b0;
            e_adr   = '0;    e_sel = '0;    e_wdat = '0;
            e_rv    = 1'b0;  e_rdata = '0;  e_err = 1'b0;  e_rwe = 1'b0;
        end else if (m_known) begin
            if (m_busy) begin
                m_elapsed++;
                if (ack || m_elapsed == TO + 1) begin
                    m_busy  = 1'b0;
                    m_pend  = 1'b1;
                    e_cyc   = 1'b0;
                    e_rv    = 1'b1;
                    e_err   = !ack;
                    e_rwe   = e_we;
                    e_rdata = (ack && !e_we) ? rd_dat : 32'h0;
                end
            end else if (m_pend) begin
                if (rsp_ready) begin
                    m_pend  = 1'b0;
                    e_rv    = 1'b0;
                    e_ready = 1'b1;
                end
            end else if (cmd_valid) begin
                m_busy    = 1'b1;
                m_elapsed = 0;
                e_ready   = 1'b0;
                e_cyc     = 1'b1;
                e_we      = cmd_we;
                e_adr     = cmd_addr;
                e_sel     = cmd_stb;
                e_wdat    = cmd_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("cmd_ready", cmd_ready, e_ready);
            check("cyc_stb_rd", {cyc, stb, rd}, {e_cyc, e_cyc, e_cyc & ~e_we});
            if (e_cyc) check("bus_fields", {adr, sel, wdat, we}, {e_adr, e_sel, e_wdat, e_we});
            check("rsp_valid", rsp_valid, e_rv);
            if (e_rv) check("rsp_fields", {rsp_rdata, rsp_err, rsp_we}, {e_rdata, e_err, e_rwe});
        end
        if (cyc === 1'b1) cyc_cnt++;
        if (rd === 1'b1) rd_cnt++;
    end

    // Called at a negedge; returns at the negedge of the first BUS cycle.
    task automatic issue(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        int n = 0;
        cmd_addr = a; cmd_wdata = d; cmd_stb = s; cmd_we = w; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) check("issue_wait", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // ACK during the k-th BUS cycle, starting from the negedge of BUS cycle 1.
    task automatic ack_on(input int k, input logic [31:0] d);
        repeat (k - 1) @(negedge clk);
        ack = 1'b1;
        rd_dat = d;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) check("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("reset_outputs", {cmd_ready, cyc, stb, we, rd, rsp_valid, rsp_err, rsp_we}, 8'b1000_0000);
        check("reset_buses", {adr, sel, wdat, rsp_rdata}, 85'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Read, immediate ACK.
        cyc_cnt = 0; rd_cnt = 0;
        issue(17'h00010, 32'h0, 4'hF, 1'b0);
        ack = 1'b1; rd_dat = 32'hDEADBEEF;
        @(negedge clk);
        ack = 1'b0;
        check("t1_valid_latency", rsp_valid, 1'b1);
        check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_err", rsp_err, 1'b0);
        check("t1_rd_cycles", rd_cnt, 1);
        take_rsp();

        // Write, ACK on the 5th bus cycle with junk on the read bus.
        cyc_cnt = 0;
        issue(17'h01004, 32'h0000_00A5, 4'b0001, 1'b1);
        ack_on(5, 32'hFFFF_FFFF);
        check("t2_cyc_cycles", cyc_cnt, 5);
        check("t2_rsp", {rsp_valid, rsp_err, rsp_we, rsp_rdata}, {1'b1, 1'b0, 1'b1, 32'h0});
        take_rsp();

        // Timeout with no ACK, then a late ACK while the response waits.
        cyc_cnt = 0;
        issue(17'h00020, 32'h0, 4'hF, 1'b0);
        wait_rsp(n);
        check("t3_latency", n, TO + 1);
        check("t3_cyc_cycles", cyc_cnt, TO + 1);
        check("t3_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
        ack = 1'b1; rd_dat = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        ack = 1'b0;
        check("t3_late_ack", {rsp_valid, rsp_err, rsp_rdata, cyc}, {1'b1, 1'b1, 32'h0, 1'b0});
        take_rsp();

        // Response back-pressure with the next command waiting.
        issue(17'h00200, 32'h0, 4'hF, 1'b0);
        ack = 1'b1; rd_dat = 32'h1111_2222;
        @(negedge clk);
        ack = 1'b0;
        cmd_addr = 17'h1FFFC; cmd_wdata = 32'hA5A5_5A5A; cmd_stb = 4'b1100; cmd_we = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_ready_low", cmd_ready, 1'b0);
            check("t4_rsp_hold", {rsp_valid, rsp_rdata}, {1'b1, 32'h1111_2222});
            @(negedge clk);
        end
        take_rsp();
        check("t4_idle_after_hs", {cmd_ready, rsp_valid, cyc}, 3'b100);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t4_next_accepted", {cyc, adr, sel, we}, {1'b1, 17'h1FFFC, 4'b1100, 1'b1});
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t4_write_rsp", {rsp_valid, rsp_we, rsp_rdata}, {1'b1, 1'b1, 32'h0});
        take_rsp();

        // Reset pulse in the middle of a bus cycle.
        issue(17'h00300, 32'h5555_AAAA, 4'hF, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_reset_ctrl", {cmd_ready, cyc, stb, we, rd, rsp_valid}, 6'b100000);
        check("t5_reset_bus", {adr, sel, wdat}, 53'h0);
        repeat (4) @(negedge clk);
        check("t5_no_rsp", rsp_valid, 1'b0);
        issue(17'h00304, 32'h0, 4'hF, 1'b0);
        ack_on(2, 32'h1234_5678);
        check("t5_read_after", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h1234_5678});
        take_rsp();

        // ACK in the very cycle the timeout limit is reached.
        cyc_cnt = 0;
        issue(17'h00400, 32'h0, 4'hF, 1'b0);
        ack_on(TO + 1, 32'h0BAD_F00D);
        check("t6_cyc_cycles", cyc_cnt, TO + 1);
        check("t6_ack_wins", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BAD_F00D});
        take_rsp();

        // Unaligned write with no byte enables still goes out as commanded.
        issue(17'h00005, 32'h0000_0077, 4'b0000, 1'b1);
        check("t7_bus", {cyc, adr, sel, wdat, we}, {1'b1, 17'h00005, 4'b0000, 32'h77, 1'b1});
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t7_rsp", {rsp_valid, rsp_err, rsp_we}, 3'b101);
        take_rsp();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
